trigger_network_controller: RTL and testbench



---
 rtl/trigger_network_controller_pkg.sv | 29 ++
 rtl/trigger_network_controller_saturating_counter.sv | 38 +++
 rtl/trigger_network_controller.sv | 127 ++++++++++++
 tb/tb_trigger_network_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_network_controller_pkg.sv
// rtl/trigger_network_controller_pkg.sv - shared actor-trigger protocol types
package TriggerCommon;

  typedef enum logic [2:0] {
    TRIG_IDLE       = 3'd0,
    TRIG_RUN        = 3'd1,
    TRIG_SLEEP      = 3'd2,
    TRIG_SYNC_SLEEP = 3'd3,
    TRIG_WAIT       = 3'd4,
    TRIG_DONE       = 3'd5
  } State;

  typedef enum logic [1:0] {
    RET_OK    = 2'd0,
    RET_SLEEP = 2'd1,
    RET_SYNC  = 2'd2,
    RET_ERROR = 2'd3
  } ReturnCode;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_START = 2'd1,
    CTRL_RUN   = 2'd2,
    CTRL_DONE  = 2'd3
  } CtrlState;

  localparam int unsigned STAT_WIDTH = 32;

endpackage

// File: rtl/trigger_network_controller_saturating_counter.sv
// rtl/trigger_network_controller_saturating_counter.sv - clearable up-counter that sticks at all ones
module saturating_counter
  import TriggerCommon::*;
#(
  parameter int unsigned WIDTH = STAT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/trigger_network_controller.sv
// rtl/trigger_network_controller.sv - kernel start/done handshake and consensus broadcast for N triggers
module trigger_network_controller
  import TriggerCommon::*;
#(
  parameter int NUM_TRIGGERS = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  output logic [NUM_TRIGGERS-1:0] trigger_start,
  input  logic [NUM_TRIGGERS-1:0] trigger_done,
  input  logic [NUM_TRIGGERS-1:0] trigger_idle,
  input  logic [NUM_TRIGGERS-1:0] trigger_sleep,
  input  logic [NUM_TRIGGERS-1:0] trigger_sync_sleep,
  input  logic [NUM_TRIGGERS-1:0] trigger_waited,
  output logic                    all_sleep,
  output logic                    all_sync_sleep,
  output logic                    all_waited,
  output logic [STAT_WIDTH-1:0]   run_cycles,
  output logic [STAT_WIDTH-1:0]   sync_rounds
);

  localparam logic [NUM_TRIGGERS-1:0] ALL_ONES = '1;

  CtrlState                state_q, state_d;
  logic [NUM_TRIGGERS-1:0] pending_q, pending_d;
  logic [NUM_TRIGGERS-1:0] done_mask_q, done_mask_d;
  logic                    sync_prev_q, sync_prev_d;
  logic [STAT_WIDTH-1:0]   run_cycles_q, sync_rounds_q;
  logic [STAT_WIDTH-1:0]   live_cycles, live_rounds;
  logic                    active, launch, round_edge;

  // Triggers act on consensus in the same cycle, so these stay pure AND trees.
  assign all_sleep      = &trigger_sleep;
  assign all_sync_sleep = &trigger_sync_sleep;
  assign all_waited     = &trigger_waited;

  assign active     = (state_q == CTRL_START) || (state_q == CTRL_RUN);
  assign launch     = (state_q == CTRL_IDLE) && ap_start;
  assign round_edge = active && all_sync_sleep && !sync_prev_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    done_mask_d = done_mask_q;
    sync_prev_d = sync_prev_q;
    case (state_q)
      CTRL_IDLE: begin
        if (ap_start) begin
          pending_d   = ALL_ONES;
          done_mask_d = '0;
          sync_prev_d = 1'b0;
          state_d     = CTRL_START;
        end
      end
      CTRL_START: begin
        pending_d   = pending_q & trigger_idle;
        done_mask_d = done_mask_q | trigger_done;
        sync_prev_d = all_sync_sleep;
        if (pending_d == '0) begin
          state_d = CTRL_RUN;
        end
      end
      CTRL_RUN: begin
        done_mask_d = done_mask_q | trigger_done;
        sync_prev_d = all_sync_sleep;
        if (done_mask_d == ALL_ONES) begin
          state_d = CTRL_DONE;
        end
      end
      CTRL_DONE: begin
        state_d = CTRL_IDLE;
      end
      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= CTRL_IDLE;
      pending_q     <= '0;
      done_mask_q   <= '0;
      sync_prev_q   <= 1'b0;
      run_cycles_q  <= '0;
      sync_rounds_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      done_mask_q <= done_mask_d;
      sync_prev_q <= sync_prev_d;
      if (state_q == CTRL_DONE) begin
        run_cycles_q  <= live_cycles;
        sync_rounds_q <= live_rounds;
      end
    end
  end

  saturating_counter #(.WIDTH(STAT_WIDTH)) u_cycle_cnt (
    .clk_i   (ap_clk),
    .rst_n_i (ap_rst_n),
    .clr_i   (launch),
    .en_i    (active),
    .count_o (live_cycles)
  );

  saturating_counter #(.WIDTH(STAT_WIDTH)) u_round_cnt (
    .clk_i   (ap_clk),
    .rst_n_i (ap_rst_n),
    .clr_i   (launch),
    .en_i    (round_edge),
    .count_o (live_rounds)
  );

  assign ap_idle       = (state_q == CTRL_IDLE);
  assign ap_done       = (state_q == CTRL_DONE);
  assign ap_ready      = ap_done;
  assign trigger_start = (state_q == CTRL_START) ? (pending_q & trigger_idle) : '0;
  // Live counters are final and frozen during DONE, so expose them a cycle early.
  assign run_cycles    = (state_q == CTRL_DONE) ? live_cycles : run_cycles_q;
  assign sync_rounds   = (state_q == CTRL_DONE) ? live_rounds : sync_rounds_q;

endmodule

// File: tb/tb_trigger_network_controller.sv
// tb/tb_trigger_network_controller.sv - randomized self-checking bench with run-level reference model
module tb_trigger_network_controller;
  localparam int N = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, ap_start;
  logic          ap_done, ap_idle, ap_ready;
  logic [N-1:0]  trigger_start, trigger_done, trigger_idle;
  logic [N-1:0]  trigger_sleep, trigger_sync_sleep, trigger_waited;
  logic          all_sleep, all_sync_sleep, all_waited;
  logic [31:0]   run_cycles, sync_rounds;

  logic          s3_start;
  logic [2:0]    s3_done, s3_idle, s3_sleep, s3_sync, s3_waited;
  logic          d3_done, d3_idle, d3_ready, d3_sleep, d3_sync, d3_waited;
  logic [2:0]    d3_start;
  logic [31:0]   d3_rc, d3_sr;

  int            checks = 0;
  int            errors = 0;
  logic          chk_en = 1'b0;
  logic [N-1:0]  exp_start;
  logic          exp_idle, exp_done;
  logic [31:0]   exp_rc = 0, exp_sr = 0;
  int            st_hi0 = 0, st_hi1 = 0, done_pulses = 0;
  logic          sync_pat [0:63];

  always #5 ap_clk = ~ap_clk;

  trigger_network_controller #(.NUM_TRIGGERS(N)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .trigger_start(trigger_start), .trigger_done(trigger_done), .trigger_idle(trigger_idle),
    .trigger_sleep(trigger_sleep), .trigger_sync_sleep(trigger_sync_sleep),
    .trigger_waited(trigger_waited), .all_sleep(all_sleep), .all_sync_sleep(all_sync_sleep),
    .all_waited(all_waited), .run_cycles(run_cycles), .sync_rounds(sync_rounds)
  );

  trigger_network_controller #(.NUM_TRIGGERS(3)) dut3 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(s3_start),
    .ap_done(d3_done), .ap_idle(d3_idle), .ap_ready(d3_ready),
    .trigger_start(d3_start), .trigger_done(s3_done), .trigger_idle(s3_idle),
    .trigger_sleep(s3_sleep), .trigger_sync_sleep(s3_sync),
    .trigger_waited(s3_waited), .all_sleep(d3_sleep), .all_sync_sleep(d3_sync),
    .all_waited(d3_waited), .run_cycles(d3_rc), .sync_rounds(d3_sr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expectations posted by the stimulus process.
  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk("trigger_start", 32'(trigger_start), 32'(exp_start));
      chk("ap_idle", 32'(ap_idle), 32'(exp_idle));
      chk("ap_done", 32'(ap_done), 32'(exp_done));
      chk("ap_ready", 32'(ap_ready), 32'(exp_done));
      chk("run_cycles", run_cycles, exp_rc);
      chk("sync_rounds", sync_rounds, exp_sr);
      chk("all_sleep", 32'(all_sleep), 32'(trigger_sleep == 2'b11));
      chk("all_sync_sleep", 32'(all_sync_sleep), 32'(trigger_sync_sleep == 2'b11));
      chk("all_waited", 32'(all_waited), 32'(trigger_waited == 2'b11));
      if (trigger_start[0]) st_hi0++;
      if (trigger_start[1]) st_hi1++;
      if (ap_done) done_pulses++;
    end
  end

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge ap_clk); #1;
      ap_start           = 1'b0;
      trigger_idle       = '1;
      trigger_done       = '0;
      trigger_sleep      = 2'($urandom);
      trigger_sync_sleep = 2'($urandom);
      trigger_waited     = 2'($urandom);
      exp_start          = '0;
      exp_idle           = 1'b1;
      exp_done           = 1'b0;
      chk_en             = 1'b1;
    end
  endtask

  // One kernel run: trigger i stays idle until START cycle ack_i, pulses done at cycle d_i.
  task automatic do_run(input int a0, input int a1, input int d0, input int d1,
                        input bit use_pat, input int rst_k);
    int ack [2];
    int dd [2];
    int s, dmax, e, rounds;
    bit prev, cur;
    logic [N-1:0] sync_v [0:63];
    logic [N-1:0] idle_v, done_v;
    ack[0] = a0; ack[1] = a1; dd[0] = d0; dd[1] = d1;
    s    = (a0 > a1) ? a0 : a1;
    dmax = (d0 > d1) ? d0 : d1;
    e    = ((dmax > s + 1) ? dmax : s + 1) + 1;
    for (int k = 0; k <= e; k++) begin
      if (use_pat) sync_v[k] = {N{sync_pat[k]}};
      else if ($urandom_range(0, 2) != 0) sync_v[k] = 2'b11;
      else sync_v[k] = 2'($urandom_range(0, 2));
    end
    rounds = 0;
    prev   = 1'b0;
    for (int k = 1; k < e; k++) begin
      cur = (sync_v[k] == 2'b11);
      if (cur && !prev) rounds++;
      prev = cur;
    end
    for (int k = 0; k <= e; k++) begin
      @(posedge ap_clk); #1;
      ap_start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        idle_v[i]    = (k < ack[i]) || (k > dd[i]);
        done_v[i]    = (k == dd[i]);
        exp_start[i] = (k >= 1) && (k < ack[i]);
      end
      trigger_idle       = idle_v;
      trigger_done       = done_v;
      trigger_sync_sleep = sync_v[k];
      trigger_sleep      = 2'($urandom);
      trigger_waited     = 2'($urandom);
      exp_idle           = (k == 0);
      exp_done           = (k == e);
      if (k == e) begin
        exp_rc = 32'(e - 1);
        exp_sr = 32'(rounds);
      end
      chk_en = (k != rst_k);
      if (k == rst_k) begin
        #1;
        chk("start_pre_reset", 32'(trigger_start), 32'(exp_start));
        ap_rst_n = 1'b0;
        #1;
        chk("rst_trigger_start", 32'(trigger_start), 32'd0);
        chk("rst_ap_idle", 32'(ap_idle), 32'd1);
        chk("rst_ap_done", 32'(ap_done), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_sync_rounds", sync_rounds, 32'd0);
        exp_rc = 0;
        exp_sr = 0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n     = 1'b1;
        ap_start     = 1'b0;
        trigger_idle = '1;
        trigger_done = '0;
        return;
      end
    end
  endtask

  initial begin
    int b0, b1, bd, a0, a1;
    ap_rst_n = 1'b0; ap_start = 1'b0;
    trigger_done = '0; trigger_idle = '1;
    trigger_sleep = '0; trigger_sync_sleep = '0; trigger_waited = '0;
    s3_start = 1'b0; s3_done = '0; s3_idle = '1;
    s3_sleep = '0; s3_sync = '0; s3_waited = '0;
    for (int k = 0; k < 64; k++) sync_pat[k] = 1'b0;
    #3;
    chk("reset_ap_idle", 32'(ap_idle), 32'd1);
    chk("reset_ap_done", 32'(ap_done), 32'd0);
    chk("reset_ap_ready", 32'(ap_ready), 32'd0);
    chk("reset_trigger_start", 32'(trigger_start), 32'd0);
    chk("reset_run_cycles", run_cycles, 32'd0);
    chk("reset_sync_rounds", sync_rounds, 32'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    idle_cycles(2);

    for (int c = 0; c < 8; c++) begin
      s3_sleep  = 3'(c);
      s3_sync   = 3'(7 - c);
      s3_waited = 3'(c ^ 5);
      #1;
      chk("n3_all_sleep", 32'(d3_sleep), 32'(c == 7));
      chk("n3_all_sync_sleep", 32'(d3_sync), 32'(c == 0));
      chk("n3_all_waited", 32'(d3_waited), 32'(c == 2));
    end
    chk("n3_idle_held", {d3_start, d3_ready, d3_done, d3_idle}, 32'd1);
    chk("n3_counters", d3_rc | d3_sr, 32'd0);

    bd = done_pulses;
    do_run(2, 2, 12, 16, 1'b0, -1);
    idle_cycles(1);
    @(negedge ap_clk); #1;
    chk("single_run_cycles", run_cycles, 32'd16);
    chk("single_done_pulses", 32'(done_pulses - bd), 32'd1);

    b0 = st_hi0; b1 = st_hi1;
    do_run(2, 5, 8, 10, 1'b0, -1);
    idle_cycles(1);
    @(negedge ap_clk); #1;
    chk("stagger_start0_cycles", 32'(st_hi0 - b0), 32'd1);
    chk("stagger_start1_cycles", 32'(st_hi1 - b1), 32'd4);
    chk("stagger_run_cycles", run_cycles, 32'd10);

    bd = done_pulses;
    do_run(2, 2, 9, 9, 1'b0, -1);
    idle_cycles(1);
    @(negedge ap_clk); #1;
    chk("simul_done_pulses", 32'(done_pulses - bd), 32'd1);
    chk("simul_run_cycles", run_cycles, 32'd9);

    sync_pat[5] = 1'b1;  sync_pat[6] = 1'b1;
    sync_pat[9] = 1'b1;  sync_pat[10] = 1'b1;
    sync_pat[13] = 1'b1; sync_pat[14] = 1'b1;
    do_run(2, 2, 20, 20, 1'b1, -1);
    idle_cycles(1);
    @(negedge ap_clk); #1;
    chk("sync_rounds_three", sync_rounds, 32'd3);

    do_run(5, 5, 10, 10, 1'b0, 2);
    idle_cycles(1);
    do_run(2, 2, 20, 20, 1'b0, 8);
    idle_cycles(1);
    do_run(3, 2, 7, 11, 1'b0, -1);

    for (int r = 0; r < 40; r++) begin
      a0 = $urandom_range(2, 5);
      a1 = $urandom_range(2, 5);
      do_run(a0, a1, a0 + $urandom_range(0, 15), a1 + $urandom_range(0, 15), 1'b0, -1);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);
    @(negedge ap_clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
